// File: rtl/inst_fetch.sv
// Instruction fetch stage: single-outstanding imem requests, fetched word and PC
// presented to decode, 1-entry skid buffer for decode stalls, redirect with flush.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_,
  output logic [31:0] imem_addr_,
  input  logic        imem_ack_,
  input  logic [31:0] imem_rdata_,
  input  logic        redirect_,
  input  logic [31:0] redirect_pc_,
  input  logic        stall_,
  output logic [31:0] inst_r,
  output logic [31:0] pc_r,
  output logic        inst_valid_,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    HOLD = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] req_addr;
  logic [31:0] fetch_pc;
  logic [31:0] skid_inst;
  logic [31:0] skid_pc;
  logic [31:0] redirect_tgt;
  logic        consume;

  // imem handshake: a transfer happens in every cycle where imem_req_ && imem_ack_;
  // imem_addr_ is held while imem_req_ is high and no ack has been seen, and a
  // req still high after an ack opens the next transaction at the new address.
  assign imem_req_    = (state == REQ) || (state == DROP);
  assign imem_addr_   = req_addr;
  assign fsm_state    = state;
  assign redirect_tgt = {redirect_pc_[31:2], 2'b00};
  assign consume      = inst_valid_ && !stall_;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= REQ;
      req_addr    <= RESET_PC;
      fetch_pc    <= RESET_PC;
      inst_r      <= NOP_INST;
      pc_r        <= RESET_PC;
      inst_valid_ <= 1'b0;
      skid_inst   <= NOP_INST;
      skid_pc     <= RESET_PC;
    end else begin
      case (state)
        REQ: begin
          if (redirect_) begin
            inst_valid_ <= 1'b0;
            inst_r      <= NOP_INST;
            skid_inst   <= NOP_INST;
            skid_pc     <= RESET_PC;
            if (imem_ack_) begin
              req_addr <= redirect_tgt;
            end else begin
              // The pending transaction must still finish on the old address.
              fetch_pc <= redirect_tgt;
              state    <= DROP;
            end
          end else if (imem_ack_) begin
            req_addr <= req_addr + 32'd4;
            if (!inst_valid_ || !stall_) begin
              inst_r      <= imem_rdata_;
              pc_r        <= req_addr;
              inst_valid_ <= 1'b1;
            end else begin
              skid_inst <= imem_rdata_;
              skid_pc   <= req_addr;
              state     <= HOLD;
            end
          end else if (consume) begin
            inst_valid_ <= 1'b0;
            inst_r      <= NOP_INST;
          end
        end

        HOLD: begin
          if (redirect_) begin
            inst_valid_ <= 1'b0;
            inst_r      <= NOP_INST;
            skid_inst   <= NOP_INST;
            skid_pc     <= RESET_PC;
            req_addr    <= redirect_tgt;
            state       <= REQ;
          end else if (!stall_) begin
            inst_r      <= skid_inst;
            pc_r        <= skid_pc;
            inst_valid_ <= 1'b1;
            state       <= REQ;
          end
        end

        DROP: begin
          if (redirect_) begin
            fetch_pc <= redirect_tgt;
          end
          if (imem_ack_) begin
            req_addr <= redirect_ ? redirect_tgt : fetch_pc;
            state    <= REQ;
          end
        end

        default: begin
          state <= REQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: behavioural imem with programmable ack latency, a consume
// scoreboard fed from an expected queue, and directed per-feature scenarios.
module tb_inst_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [1:0]  S_REQ    = 2'd0;
  localparam logic [1:0]  S_HOLD   = 2'd1;
  localparam logic [1:0]  S_DROP   = 2'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_;
  logic [31:0] imem_addr_;
  logic        imem_ack_;
  logic [31:0] imem_rdata_;
  logic        redirect_;
  logic [31:0] redirect_pc_;
  logic        stall_;
  logic [31:0] inst_r;
  logic [31:0] pc_r;
  logic        inst_valid_;
  logic [1:0]  fsm_state;

  int latency;
  int wait_cnt;
  int n_vec = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
    .clk(clk), .rst(rst),
    .imem_req_(imem_req_), .imem_addr_(imem_addr_),
    .imem_ack_(imem_ack_), .imem_rdata_(imem_rdata_),
    .redirect_(redirect_), .redirect_pc_(redirect_pc_),
    .stall_(stall_),
    .inst_r(inst_r), .pc_r(pc_r), .inst_valid_(inst_valid_),
    .fsm_state(fsm_state)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'h0050_0093;
      32'h0000_0004: mem_word = 32'h00a0_0113;
      default:       mem_word = a ^ 32'hC0DE_0013;
    endcase
  endfunction

  // Memory model: ack once req has been high for `latency` cycles.
  assign imem_ack_   = imem_req_ && (wait_cnt >= latency);
  assign imem_rdata_ = mem_word(imem_addr_);

  always @(posedge clk or posedge rst) begin
    if (rst) wait_cnt <= 0;
    else if (imem_req_ && imem_ack_) wait_cnt <= 0;
    else if (imem_req_) wait_cnt <= wait_cnt + 1;
  end

  // Scoreboard: every instruction the decoder consumes must match the queue head.
  always @(negedge clk) begin
    if (!rst && inst_valid_ && !stall_) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL consume_unexpected got pc=%h inst=%h want nothing", pc_r, inst_r);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({pc_r, inst_r} !== e) begin
          n_err++;
          $display("FAIL consume got pc=%h inst=%h want pc=%h inst=%h", pc_r, inst_r, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic push_exp(input logic [31:0] a);
    exp_q.push_back({a, mem_word(a)});
  endtask

  // Park with stall high and zero-wait memory until the skid fills.
  task automatic settle;
    int guard;
    stall_  = 1'b1;
    latency = 0;
    guard   = 0;
    while (fsm_state != S_HOLD && guard < 10) begin
      tick();
      guard++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; stall_ = 1'b1; redirect_ = 1'b0; redirect_pc_ = '0; latency = 0;
    repeat (2) @(posedge clk);
    #2;
    n_vec++; if (inst_r !== NOP_INST) begin n_err++; $display("FAIL rst_inst got %h want %h", inst_r, NOP_INST); end
    n_vec++; if (pc_r !== RESET_PC) begin n_err++; $display("FAIL rst_pc got %h want %h", pc_r, RESET_PC); end
    n_vec++; if (inst_valid_ !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", inst_valid_); end
    n_vec++; if (imem_addr_ !== RESET_PC) begin n_err++; $display("FAIL rst_addr got %h want %h", imem_addr_, RESET_PC); end
    n_vec++; if (fsm_state !== S_REQ) begin n_err++; $display("FAIL rst_state got %0d want %0d", fsm_state, S_REQ); end
    rst = 1'b0;
  endtask

  task automatic test_zero_wait;
    push_exp(32'h0);
    push_exp(32'h4);
    stall_ = 1'b0;
    n_vec++; if (imem_req_ !== 1'b1 || imem_addr_ !== 32'h0) begin n_err++; $display("FAIL zw_c0 got req=%b addr=%h want 1/0", imem_req_, imem_addr_); end
    tick();
    n_vec++; if (imem_addr_ !== 32'h4) begin n_err++; $display("FAIL zw_addr1 got %h want 4", imem_addr_); end
    n_vec++; if (inst_valid_ !== 1'b1 || inst_r !== 32'h0050_0093 || pc_r !== 32'h0) begin n_err++; $display("FAIL zw_out1 got v=%b %h/%h want 1 00500093/0", inst_valid_, inst_r, pc_r); end
    tick();
    n_vec++; if (imem_addr_ !== 32'h8) begin n_err++; $display("FAIL zw_addr2 got %h want 8", imem_addr_); end
    n_vec++; if (inst_valid_ !== 1'b1 || inst_r !== 32'h00a0_0113 || pc_r !== 32'h4) begin n_err++; $display("FAIL zw_out2 got v=%b %h/%h want 1 00a00113/4", inst_valid_, inst_r, pc_r); end
  endtask

  task automatic test_stall_skid;
    stall_ = 1'b1;
    push_exp(32'h8);
    n_vec++; if (imem_ack_ !== 1'b1) begin n_err++; $display("FAIL sk_ack got %b want 1", imem_ack_); end
    tick();
    n_vec++; if (fsm_state !== S_HOLD || imem_req_ !== 1'b0) begin n_err++; $display("FAIL sk_hold got st=%0d req=%b want 1/0", fsm_state, imem_req_); end
    n_vec++; if (inst_r !== mem_word(32'h4)) begin n_err++; $display("FAIL sk_keep got %h want %h", inst_r, mem_word(32'h4)); end
    tick();
    n_vec++; if (imem_req_ !== 1'b0) begin n_err++; $display("FAIL sk_req2 got %b want 0", imem_req_); end
    tick();
    stall_ = 1'b0;
    n_vec++; if (imem_req_ !== 1'b0 || pc_r !== 32'h4) begin n_err++; $display("FAIL sk_c5 got req=%b pc=%h want 0/4", imem_req_, pc_r); end
    tick();
    n_vec++; if (inst_r !== mem_word(32'h8) || pc_r !== 32'h8 || inst_valid_ !== 1'b1) begin n_err++; $display("FAIL sk_out8 got v=%b %h/%h want 1 %h/8", inst_valid_, inst_r, pc_r, mem_word(32'h8)); end
    n_vec++; if (imem_req_ !== 1'b1 || imem_addr_ !== 32'hC) begin n_err++; $display("FAIL sk_resume got req=%b addr=%h want 1/c", imem_req_, imem_addr_); end
    tick();
    stall_ = 1'b1;
    n_vec++; if (inst_r !== mem_word(32'hC) || pc_r !== 32'hC) begin n_err++; $display("FAIL sk_outc got %h/%h want %h/c", inst_r, pc_r, mem_word(32'hC)); end
    settle();
    n_vec++; if (fsm_state !== S_HOLD || exp_q.size() != 0) begin n_err++; $display("FAIL sk_end got st=%0d q=%0d want 1/0", fsm_state, exp_q.size()); end
  endtask

  task automatic test_redirect_pending;
    latency = 3;
    redirect_ = 1'b1; redirect_pc_ = 32'h8;
    tick();
    n_vec++; if (fsm_state !== S_REQ || imem_addr_ !== 32'h8 || inst_valid_ !== 1'b0 || inst_r !== NOP_INST) begin n_err++; $display("FAIL rp_flush got st=%0d addr=%h v=%b inst=%h want 0/8/0/nop", fsm_state, imem_addr_, inst_valid_, inst_r); end
    redirect_pc_ = 32'h100; stall_ = 1'b0;
    tick();
    redirect_ = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (fsm_state !== S_DROP || imem_req_ !== 1'b1 || imem_addr_ !== 32'h8 || inst_valid_ !== 1'b0) begin n_err++; $display("FAIL rp_drop%0d got st=%0d req=%b addr=%h v=%b want 2/1/8/0", i, fsm_state, imem_req_, imem_addr_, inst_valid_); end
      if (i < 2) tick();
    end
    push_exp(32'h100);
    tick();
    n_vec++; if (imem_addr_ !== 32'h100 || inst_valid_ !== 1'b0) begin n_err++; $display("FAIL rp_new got addr=%h v=%b want 100/0", imem_addr_, inst_valid_); end
    for (int i = 0; i < 10 && !inst_valid_; i++) tick();
    n_vec++; if (inst_valid_ !== 1'b1) begin n_err++; $display("FAIL rp_timeout got v=%b want 1", inst_valid_); end
    tick();
    settle();
    n_vec++; if (fsm_state !== S_HOLD || exp_q.size() != 0) begin n_err++; $display("FAIL rp_end got st=%0d q=%0d want 1/0", fsm_state, exp_q.size()); end
  endtask

  task automatic test_redirect_ack;
    redirect_ = 1'b1; redirect_pc_ = 32'hC;
    tick();
    n_vec++; if (imem_addr_ !== 32'hC || imem_ack_ !== 1'b1 || inst_valid_ !== 1'b0) begin n_err++; $display("FAIL ra_setup got addr=%h ack=%b v=%b want c/1/0", imem_addr_, imem_ack_, inst_valid_); end
    redirect_pc_ = 32'h40;
    tick();
    n_vec++; if (imem_addr_ !== 32'h40 || inst_valid_ !== 1'b0 || inst_r !== NOP_INST) begin n_err++; $display("FAIL ra_discard got addr=%h v=%b inst=%h want 40/0/nop", imem_addr_, inst_valid_, inst_r); end
    redirect_pc_ = 32'h43;
    tick();
    n_vec++; if (imem_addr_ !== 32'h40) begin n_err++; $display("FAIL ra_align got %h want 40", imem_addr_); end
    redirect_ = 1'b0; stall_ = 1'b0;
    push_exp(32'h40);
    push_exp(32'h44);
    tick();
    n_vec++; if (pc_r !== 32'h40) begin n_err++; $display("FAIL ra_pc got %h want 40", pc_r); end
    tick();
    n_vec++; if (imem_addr_ !== 32'h48) begin n_err++; $display("FAIL ra_addr got %h want 48", imem_addr_); end
    tick();
    settle();
    n_vec++; if (fsm_state !== S_HOLD || exp_q.size() != 0) begin n_err++; $display("FAIL ra_end got st=%0d q=%0d want 1/0", fsm_state, exp_q.size()); end
  endtask

  task automatic test_wrap;
    redirect_ = 1'b1; redirect_pc_ = 32'hFFFF_FFFC;
    tick();
    n_vec++; if (imem_addr_ !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wr_addr0 got %h want fffffffc", imem_addr_); end
    redirect_ = 1'b0; stall_ = 1'b0;
    push_exp(32'hFFFF_FFFC);
    push_exp(32'h0);
    tick();
    n_vec++; if (imem_addr_ !== 32'h0 || pc_r !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wr_c1 got addr=%h pc=%h want 0/fffffffc", imem_addr_, pc_r); end
    tick();
    n_vec++; if (imem_addr_ !== 32'h4 || pc_r !== 32'h0) begin n_err++; $display("FAIL wr_c2 got addr=%h pc=%h want 4/0", imem_addr_, pc_r); end
    tick();
    settle();
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL wr_end got q=%0d want 0", exp_q.size()); end
  endtask

  task automatic test_async_reset;
    latency = 3;
    redirect_ = 1'b1; redirect_pc_ = 32'h200;
    tick();
    redirect_pc_ = 32'h300;
    tick();
    redirect_ = 1'b0;
    n_vec++; if (fsm_state !== S_DROP || imem_addr_ !== 32'h200) begin n_err++; $display("FAIL ar_drop got st=%0d addr=%h want 2/200", fsm_state, imem_addr_); end
    #1 rst = 1'b1;
    #1;
    n_vec++; if (fsm_state !== S_REQ || imem_addr_ !== RESET_PC) begin n_err++; $display("FAIL ar_state got st=%0d addr=%h want 0/%h", fsm_state, imem_addr_, RESET_PC); end
    n_vec++; if (pc_r !== RESET_PC || inst_r !== NOP_INST || inst_valid_ !== 1'b0) begin n_err++; $display("FAIL ar_out got pc=%h inst=%h v=%b want %h/nop/0", pc_r, inst_r, inst_valid_, RESET_PC); end
    tick();
    rst = 1'b0; latency = 0;
    n_vec++; if (imem_req_ !== 1'b1 || imem_addr_ !== RESET_PC) begin n_err++; $display("FAIL ar_first got req=%b addr=%h want 1/%h", imem_req_, imem_addr_, RESET_PC); end
    tick();
    n_vec++; if (inst_valid_ !== 1'b1 || inst_r !== 32'h0050_0093 || pc_r !== RESET_PC) begin n_err++; $display("FAIL ar_fetch got v=%b %h/%h want 1 00500093/0", inst_valid_, inst_r, pc_r); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_zero_wait();
    test_stall_skid();
    test_redirect_pending();
    test_redirect_ack();
    test_wrap();
    test_async_reset();
    tick();
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL final_queue got %0d want 0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
